// File: rtl/chon_xung_ctrl_pkg.sv
// Shared definitions for the LCD-kit rate controller: FSM state encodings and
// rate-select constants (FREZ_SLOW/FREZ_FAST are also used by the LCD sequencer).
package chon_xung_ctrl_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam logic FREZ_SLOW = 1'b0;
  localparam logic FREZ_FAST = 1'b1;

  // Counter width that never collapses to zero bits for tiny parameter values.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chon_xung_ctrl_debounce.sv
// Button front end: 2-FF synchronizer, counting debouncer and registered edge detect.
// The debouncer is present only when CHON_XUNG_DEBOUNCE_EN is defined; otherwise deb = synchronizer output.
module nut_debounce
  import chon_xung_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic deb,
  output logic press
);

  logic sync1_q, sync2_q;
  logic deb_lvl;
  logic deb_prev_q, deb_prev_d;
  logic press_q, press_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

`ifdef CHON_XUNG_DEBOUNCE_EN
  localparam int unsigned DW = cnt_width(DEB_CYC);

  logic          deb_q, deb_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  // Flip only after DEB_CYC consecutive disagreeing samples; any agreement restarts the count.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    deb_d  = deb_q;
    dcnt_d = '0;
    if (sync2_q != deb_q) begin
      if (dcnt_q == DW'(DEB_CYC - 1)) begin
        deb_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_q  <= 1'b0;
      dcnt_q <= '0;
    end else begin
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
    end
  end

  assign deb_lvl = deb_q;
`else
  assign deb_lvl = sync2_q;
`endif

  always_comb begin
    deb_prev_d = deb_lvl;
    press_d    = deb_lvl & ~deb_prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      deb_prev_q <= deb_prev_d;
      press_q    <= press_d;
    end
  end

  assign deb   = deb_lvl;
  assign press = press_q;

endmodule

// File: rtl/chon_xung_ctrl.sv
// Glitch-free 5/10 Hz blink clock generator with debounced rate toggle button.
// Define CHON_XUNG_DEBOUNCE_EN for the real debouncer; leave it undefined only for fast simulation.
module chon_xung_ctrl
  import chon_xung_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned SLOW_HZ = 5,
  parameter int unsigned FAST_HZ = 10,
  parameter int unsigned DEB_MS  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic frez_o,
  output logic clko,
  output logic tick_o,
  output logic pend_o
);

  localparam int unsigned HALF_S  = CLK_HZ / (2 * SLOW_HZ);
  localparam int unsigned HALF_F  = CLK_HZ / (2 * FAST_HZ);
  localparam int unsigned DEB_CYC = CLK_HZ / 1000 * DEB_MS;
  localparam int unsigned CW      = cnt_width(HALF_S);

  logic press;
  logic deb_unused;

  nut_debounce #(
    .DEB_CYC (DEB_CYC)
  ) u_nut_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .deb   (deb_unused),
    .press (press)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clko_q, clko_d;
  logic          tick_q, tick_d;
  logic          frez_q, frez_d;
  logic          pend_q, pend_d;

  logic [CW-1:0] lim_m1;
  logic          wrap;
  logic          fall_wrap;

  assign lim_m1    = (frez_q == FREZ_FAST) ? CW'(HALF_F - 1) : CW'(HALF_S - 1);
  assign wrap      = (cnt_q == lim_m1);
  assign fall_wrap = wrap & clko_q;

  // A switch only ever lands on a falling wrap, where the counter and clko are already restarting,
  // so the new limit starts with a fresh low phase and no half-period is shortened.
  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + 1'b1;
    clko_d  = wrap ? ~clko_q : clko_q;
    tick_d  = wrap & ~clko_q;
    frez_d  = frez_q;
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (press) state_d = ST_PEND;
      end
      ST_PEND: begin
        if (fall_wrap) begin
          frez_d  = ~frez_q;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    pend_d = (state_d == ST_PEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      clko_q  <= 1'b0;
      tick_q  <= 1'b0;
      frez_q  <= FREZ_SLOW;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clko_q  <= clko_d;
      tick_q  <= tick_d;
      frez_q  <= frez_d;
      pend_q  <= pend_d;
    end
  end

  assign frez_o = frez_q;
  assign clko   = clko_q;
  assign tick_o = tick_q;
  assign pend_o = pend_q;

endmodule

// File: tb/tb_chon_xung_ctrl.sv
// Self-checking bench for chon_xung_ctrl: per-cycle vector table plus a clko-edge scoreboard.
module tb_chon_xung_ctrl;

  localparam int DEB_CYC = 20;
`ifdef CHON_XUNG_DEBOUNCE_EN
  localparam int LAT         = DEB_CYC + 4;
  localparam int BOUNCE_PEND = 60 + LAT;
`else
  localparam int LAT         = 4;
  localparam int BOUNCE_PEND = 30 + LAT;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;
  logic frez_o, clko, tick_o, pend_o;

  chon_xung_ctrl #(
    .CLK_HZ  (1000),
    .SLOW_HZ (5),
    .FAST_HZ (10),
    .DEB_MS  (20)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .frez_o (frez_o),
    .clko   (clko),
    .tick_o (tick_o),
    .pend_o (pend_o)
  );

  always #5 clk = ~clk;

  // Cycle n = state after the n-th rising edge following reset release.
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  typedef struct {
    int cyc;
    bit rise;
  } ev_t;

  typedef struct {
    int scen;
    int cyc;
    bit drv;
    bit btn;
    bit chk;
    bit clko;
    bit tick;
    bit frez;
    bit pend;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[$];

  function automatic void add_drv(input int s, input int c, input bit b);
    vec_t v;
    v = '{s, c, 1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs.push_back(v);
  endfunction

  function automatic void add_chk(input int s, input int c, input bit ck, input bit tk,
                                  input bit fz, input bit pd);
    vec_t v;
    v = '{s, c, 1'b0, 1'b0, 1'b1, ck, tk, fz, pd};
    vecs.push_back(v);
  endfunction

  function automatic void push_ev(input int c, input bit r);
    ev_t e;
    e.cyc  = c;
    e.rise = r;
    exp_q.push_back(e);
  endfunction

  // Scoreboard: every clko transition must match the next expected edge; tick must sit on rises only.
  logic prev_clko = 1'b0;
  logic prev_pend = 1'b0;
  int   pend_rises = 0;
  ev_t  mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (clko !== prev_clko) begin
        if (exp_q.size() == 0) begin
          check("clko_edge_unexpected", cyc, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("clko_edge_cycle", cyc, mon_e.cyc);
          check("clko_edge_dir", int'(clko), int'(mon_e.rise));
        end
      end
      if (tick_o || (clko && !prev_clko))
        check("tick_on_rise", int'(tick_o), int'(clko && !prev_clko));
      if (pend_o && !prev_pend) pend_rises++;
    end
    prev_clko <= clko;
    prev_pend <= pend_o;
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    btn = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_clko", int'(clko), 0);
    check("rst_tick", int'(tick_o), 0);
    check("rst_frez", int'(frez_o), 0);
    check("rst_pend", int'(pend_o), 0);
    exp_q.delete();
    pend_rises = 0;
    rst = 1'b0;
  endtask

  task automatic run_scen(input int s, input int last);
    for (int c = 1; c <= last; c++) begin
      wait_cyc(c);
      foreach (vecs[i]) begin
        if (vecs[i].scen == s && vecs[i].cyc == c && vecs[i].chk) begin
          check($sformatf("s%0d_clko", s), int'(clko),   int'(vecs[i].clko));
          check($sformatf("s%0d_tick", s), int'(tick_o), int'(vecs[i].tick));
          check($sformatf("s%0d_frez", s), int'(frez_o), int'(vecs[i].frez));
          check($sformatf("s%0d_pend", s), int'(pend_o), int'(vecs[i].pend));
        end
      end
      foreach (vecs[i]) begin
        if (vecs[i].scen == s && vecs[i].cyc == c && vecs[i].drv) btn = vecs[i].btn;
      end
    end
  endtask

  initial begin
    // s0: free run at SLOW
    add_chk(0, 1,   0, 0, 0, 0);
    add_chk(0, 99,  0, 0, 0, 0);
    add_chk(0, 100, 1, 1, 0, 0);
    add_chk(0, 101, 1, 0, 0, 0);
    add_chk(0, 199, 1, 0, 0, 0);
    add_chk(0, 200, 0, 0, 0, 0);
    add_chk(0, 300, 1, 1, 0, 0);
    add_chk(0, 420, 0, 0, 0, 0);
    // s1: clean press, switch at first falling wrap, then a new request at FAST
    add_drv(1, 30, 1);
    add_chk(1, 30 + LAT - 1, 0, 0, 0, 0);
    add_chk(1, 30 + LAT,     0, 0, 0, 1);
    add_drv(1, 70, 0);
    add_chk(1, 199, 1, 0, 0, 1);
    add_chk(1, 200, 0, 0, 1, 0);
    add_chk(1, 249, 0, 0, 1, 0);
    add_chk(1, 250, 1, 1, 1, 0);
    add_chk(1, 299, 1, 0, 1, 0);
    add_chk(1, 300, 0, 0, 1, 0);
    add_drv(1, 300, 1);
    add_drv(1, 320, 0);
    add_chk(1, 330, 0, 0, 1, 1);
    // s2: after a 1-cycle reset during PEND at FAST
    add_chk(2, 99,  0, 0, 0, 0);
    add_chk(2, 100, 1, 1, 0, 0);
    add_chk(2, 200, 0, 0, 0, 0);
    // s3: bouncy press
    add_drv(3, 30, 1);
    add_drv(3, 35, 0);
    add_drv(3, 40, 1);
    add_drv(3, 45, 0);
    add_drv(3, 50, 1);
    add_drv(3, 55, 0);
    add_drv(3, 60, 1);
    add_chk(3, BOUNCE_PEND - 1, 0, 0, 0, 0);
    add_chk(3, BOUNCE_PEND,     0, 0, 0, 1);
    add_chk(3, 200, 0, 0, 1, 0);
    add_drv(3, 240, 0);
    add_chk(3, 250, 1, 1, 1, 0);
    // s4: press lands on the falling wrap in RUN; switch deferred to the next one
    add_drv(4, 200 - LAT, 1);
    add_chk(4, 199, 1, 0, 0, 0);
    add_chk(4, 200, 0, 0, 0, 1);
    add_drv(4, 240, 0);
    add_chk(4, 300, 1, 1, 0, 1);
    add_chk(4, 399, 1, 0, 0, 1);
    add_chk(4, 400, 0, 0, 1, 0);
    add_chk(4, 450, 1, 1, 1, 0);
    // s5: second press while pending is ignored
    add_drv(5, 30, 1);
    add_drv(5, 70, 0);
    add_drv(5, 110, 1);
    add_chk(5, 150, 1, 0, 0, 1);
    add_drv(5, 150, 0);
    add_chk(5, 200, 0, 0, 1, 0);
    add_chk(5, 201, 0, 0, 1, 0);
    add_chk(5, 350, 1, 1, 1, 0);
    add_chk(5, 400, 0, 0, 1, 0);

    do_reset(2);
    push_ev(100, 1); push_ev(200, 0); push_ev(300, 1); push_ev(400, 0);
    run_scen(0, 420);
    check("s0_events_done", exp_q.size(), 0);

    do_reset(2);
    push_ev(100, 1); push_ev(200, 0); push_ev(250, 1); push_ev(300, 0);
    run_scen(1, 340);
    check("s1_events_done", exp_q.size(), 0);

    do_reset(1);
    push_ev(100, 1); push_ev(200, 0);
    run_scen(2, 210);
    check("s2_events_done", exp_q.size(), 0);

    do_reset(2);
    push_ev(100, 1); push_ev(200, 0); push_ev(250, 1);
    run_scen(3, 260);
    check("s3_one_pend", pend_rises, 1);
    check("s3_events_done", exp_q.size(), 0);

    do_reset(2);
    push_ev(100, 1); push_ev(200, 0); push_ev(300, 1); push_ev(400, 0); push_ev(450, 1);
    run_scen(4, 460);
    check("s4_one_pend", pend_rises, 1);
    check("s4_events_done", exp_q.size(), 0);

    do_reset(2);
    push_ev(100, 1); push_ev(200, 0); push_ev(250, 1);
    push_ev(300, 0); push_ev(350, 1); push_ev(400, 0);
    run_scen(5, 410);
    check("s5_one_pend", pend_rises, 1);
    check("s5_events_done", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
